rolling_window_stats: RTL and testbench

Sliding-window statistics stage that sits directly upstream of the Z-score trade decision stage. It accepts one 8-bit price sample per valid strobe and keeps the last N samples in a circular buffer. It maintains running sums of the samples and of their squares. Once the window is full, it emits the window mean, the window mean-of-squares and the current sample with a valid pulse, in the exact form the Z-score stage consumes.

---
 rtl/rolling_window_stats.sv | 104 ++++++++++
 tb/tb_rolling_window_stats.sv | 161 ++++++++++++++++
 2 files changed

// File: rtl/rolling_window_stats.sv
// Sliding-window mean and mean-of-squares over the last 2^WINDOW_LOG2 price samples,
// formatted for the downstream Z-score decision stage.
module rolling_window_stats #(
   parameter int unsigned WINDOW_LOG2 = 3
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [7:0]  data_in,
   input  logic        data_valid_in,
   input  logic        clear,
   output logic [7:0]  N_mean,
   output logic [15:0] N_sqr_mean,
   output logic [7:0]  current_data,
   output logic        data_valid_pre
);

   localparam int unsigned N   = 1 << WINDOW_LOG2;
   localparam int unsigned SW  = 8 + WINDOW_LOG2;
   localparam int unsigned QW  = 16 + WINDOW_LOG2;
   localparam logic [WINDOW_LOG2:0] FILL_LAST = (WINDOW_LOG2 + 1)'(N - 1);

   typedef enum logic {
      FILL,
      RUN
   } state_t;

   state_t                 state, state_nxt;
   logic [7:0]             buf_mem [N];
   logic [WINDOW_LOG2-1:0] wptr;
   logic [WINDOW_LOG2:0]   fill_cnt;
   logic [SW-1:0]          sum, sum_n;
   logic [QW-1:0]          sqsum, sqsum_n;
   logic [7:0]             oldest;
   logic [15:0]            x_sq, old_sq;
   logic                   accept, window_done;

   assign accept      = data_valid_in && !clear;
   assign window_done = (state == RUN) || (fill_cnt == FILL_LAST);

   // Stale buffer contents after a clear are masked here rather than erased.
   assign oldest = (state == RUN) ? buf_mem[wptr] : '0;
   assign x_sq   = {8'd0, data_in} * {8'd0, data_in};
   assign old_sq = {8'd0, oldest} * {8'd0, oldest};

   assign sum_n   = sum + SW'(data_in) - SW'(oldest);
   assign sqsum_n = sqsum + QW'(x_sq) - QW'(old_sq);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= FILL;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      if (clear)
         state_nxt = FILL;
      else if (accept && state == FILL && fill_cnt == FILL_LAST)
         state_nxt = RUN;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int unsigned i = 0; i < N; i++) buf_mem[i] <= '0;
      end else if (accept) begin
         buf_mem[wptr] <= data_in;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wptr     <= '0;
         fill_cnt <= '0;
         sum      <= '0;
         sqsum    <= '0;
      end else if (clear) begin
         wptr     <= '0;
         fill_cnt <= '0;
         sum      <= '0;
         sqsum    <= '0;
      end else if (accept) begin
         wptr  <= wptr + 1'b1;
         sum   <= sum_n;
         sqsum <= sqsum_n;
         if (state == FILL) fill_cnt <= fill_cnt + 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         N_mean         <= '0;
         N_sqr_mean     <= '0;
         current_data   <= '0;
         data_valid_pre <= 1'b0;
      end else if (accept && window_done) begin
         N_mean         <= 8'(sum_n >> WINDOW_LOG2);
         N_sqr_mean     <= 16'(sqsum_n >> WINDOW_LOG2);
         current_data   <= data_in;
         data_valid_pre <= 1'b1;
      end else begin
         data_valid_pre <= 1'b0;
      end
   end

endmodule

// File: tb/tb_rolling_window_stats.sv
// Directed bench for rolling_window_stats (N=8) with hand-computed expected statistics.
module tb_rolling_window_stats;

   logic        clk = 1'b0;
   logic        rst;
   logic [7:0]  data_in;
   logic        data_valid_in;
   logic        clear;
   logic [7:0]  N_mean;
   logic [15:0] N_sqr_mean;
   logic [7:0]  current_data;
   logic        data_valid_pre;

   int n_checks = 0;
   int n_fail   = 0;

   rolling_window_stats #(.WINDOW_LOG2(3)) dut (
      .clk            (clk),
      .rst            (rst),
      .data_in        (data_in),
      .data_valid_in  (data_valid_in),
      .clear          (clear),
      .N_mean         (N_mean),
      .N_sqr_mean     (N_sqr_mean),
      .current_data   (current_data),
      .data_valid_pre (data_valid_pre)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
      end
   endtask

   task automatic drive(input logic [7:0] x);
      @(negedge clk);
      data_in       = x;
      data_valid_in = 1'b1;
      clear         = 1'b0;
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      @(negedge clk);
      data_valid_in = 1'b0;
      clear         = 1'b0;
      @(posedge clk);
      #1;
   endtask

   task automatic do_clear();
      @(negedge clk);
      data_valid_in = 1'b0;
      clear         = 1'b1;
      @(posedge clk);
      #1;
      @(negedge clk);
      clear = 1'b0;
   endtask

   task automatic expect_out(input string tag, input int m, input int s, input int c);
      check({tag, "_valid"}, data_valid_pre, 1);
      check({tag, "_mean"}, N_mean, m);
      check({tag, "_sqr"}, N_sqr_mean, s);
      check({tag, "_cur"}, current_data, c);
   endtask

   task automatic expect_hold(input string tag, input int m, input int s, input int c);
      check({tag, "_valid"}, data_valid_pre, 0);
      check({tag, "_mean"}, N_mean, m);
      check({tag, "_sqr"}, N_sqr_mean, s);
      check({tag, "_cur"}, current_data, c);
   endtask

   initial begin
      rst = 1'b1; data_in = '0; data_valid_in = 1'b0; clear = 1'b0;
      #3;
      expect_hold("reset", 0, 0, 0);
      @(negedge clk); rst = 1'b0;

      // warm-up
      for (int i = 0; i < 7; i++) begin
         drive(8'd10);
         check("warm_nopulse", data_valid_pre, 0);
      end
      drive(8'd10);
      expect_out("warm8", 10, 100, 10);
      idle();
      expect_hold("warm_idle", 10, 100, 10);

      // ramp and wrap
      do_clear();
      for (int i = 1; i <= 7; i++) begin
         drive(8'(i));
         check("ramp_nopulse", data_valid_pre, 0);
      end
      drive(8'd8);
      expect_out("ramp8", 4, 25, 8);
      drive(8'd9);
      expect_out("ramp_wrap", 5, 35, 9);

      // max values
      do_clear();
      for (int i = 0; i < 7; i++) drive(8'd255);
      check("max_nopulse7", data_valid_pre, 0);
      drive(8'd255);
      expect_out("max8", 255, 65025, 255);
      drive(8'd0);
      expect_out("max_evict", 223, 56896, 0);

      // gapped input
      drive(8'd100);
      expect_out("gap1", 203, 50018, 100);
      for (int i = 0; i < 2; i++) begin idle(); expect_hold("gap1_idle", 203, 50018, 100); end
      drive(8'd0);
      expect_out("gap2", 171, 41890, 0);
      for (int i = 0; i < 3; i++) begin idle(); expect_hold("gap2_idle", 171, 41890, 0); end
      drive(8'd50);
      expect_out("gap3", 146, 34075, 50);
      idle();
      expect_hold("gap3_idle", 146, 34075, 50);

      // clear with a coincident sample
      @(negedge clk);
      data_in = 8'd200; data_valid_in = 1'b1; clear = 1'b1;
      @(posedge clk); #1;
      expect_hold("clr_discard", 146, 34075, 50);
      for (int i = 0; i < 7; i++) begin
         drive(8'd50);
         check("clr_nopulse", data_valid_pre, 0);
      end
      drive(8'd50);
      expect_out("clr8", 50, 2500, 50);

      // async reset between edges
      @(negedge clk);
      data_valid_in = 1'b0;
      #1 rst = 1'b1;
      #1;
      expect_hold("async_rst", 0, 0, 0);
      @(negedge clk);
      @(negedge clk); rst = 1'b0;
      for (int i = 0; i < 7; i++) begin
         drive(8'd20);
         check("rst_nopulse", data_valid_pre, 0);
      end
      drive(8'd20);
      expect_out("rst8", 20, 400, 20);
      idle();
      check("final_idle_valid", data_valid_pre, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
